// File: rtl/mips_pkg.sv
// Shared encodings for the 5-stage MIPS pipeline control logic.
package mips_pkg;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b01;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef enum logic [0:0] {
    RUN     = 1'b0,
    MD_WAIT = 1'b1
  } hazard_state_e;

endpackage

// File: rtl/fwd_unit.sv
// EX-stage operand forwarding select: EX/MEM beats MEM/WB, $0 is never forwarded.
module fwd_unit
  import mips_pkg::*;
(
  input  logic [4:0] ex_rs,
  input  logic [4:0] ex_rt,
  input  logic [4:0] mem_rd,
  input  logic       mem_regwrite,
  input  logic [4:0] wb_rd,
  input  logic       wb_regwrite,
  output logic [1:0] fwd_a,
  output logic [1:0] fwd_b
);

  logic mem_valid;
  logic wb_valid;

  assign mem_valid = mem_regwrite && (mem_rd != REG_ZERO);
  assign wb_valid  = wb_regwrite && (wb_rd != REG_ZERO);

  always_comb begin
    fwd_a = FWD_RF;
    if (mem_valid && (mem_rd == ex_rs)) begin
      fwd_a = FWD_MEM;
    end else if (wb_valid && (wb_rd == ex_rs)) begin
      fwd_a = FWD_WB;
    end
  end

  always_comb begin
    fwd_b = FWD_RF;
    if (mem_valid && (mem_rd == ex_rt)) begin
      fwd_b = FWD_MEM;
    end else if (wb_valid && (wb_rd == ex_rt)) begin
      fwd_b = FWD_WB;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline controller: load-use bubbles, branch flushes, mul/div hold, forwarding
// selects and a saturating stall-cycle counter.
module hazard_ctrl
  import mips_pkg::*;
#(
  parameter int unsigned MD_LAT = 4,
  parameter int unsigned CNT_W  = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic [4:0]       ex_rs,
  input  logic [4:0]       ex_rt,
  input  logic [4:0]       ex_rd,
  input  logic             ex_memread,
  input  logic [4:0]       mem_rd,
  input  logic             mem_regwrite,
  input  logic [4:0]       wb_rd,
  input  logic             wb_regwrite,
  input  logic             branch_taken,
  input  logic             md_start,
  input  logic             perf_clr,
  output logic             pc_we,
  output logic             ifid_we,
  output logic             ifid_flush,
  output logic             idex_we,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             md_busy,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam logic [3:0] MD_INIT = 4'(MD_LAT - 1);

  hazard_state_e    state_q, state_d;
  logic [3:0]       md_cnt_q, md_cnt_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic             lu;

  assign lu = ex_memread && (ex_rd != REG_ZERO) &&
              ((ex_rd == id_rs) || (id_uses_rt && (ex_rd == id_rt)));

  always_comb begin
    state_d     = state_q;
    md_cnt_d    = md_cnt_q;
    pc_we       = 1'b1;
    ifid_we     = 1'b1;
    idex_we     = 1'b1;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    md_busy     = 1'b0;
    if (rst) begin
      pc_we       = 1'b0;
      ifid_we     = 1'b0;
      idex_we     = 1'b0;
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      exmem_flush = 1'b1;
    end else begin
      unique case (state_q)
        RUN: begin
          // A taken branch squashes the dependent ID instruction and drops md_start.
          if (branch_taken) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
          end else if (md_start) begin
            pc_we       = 1'b0;
            ifid_we     = 1'b0;
            idex_we     = 1'b0;
            exmem_flush = 1'b1;
            state_d     = MD_WAIT;
            md_cnt_d    = MD_INIT;
          end else if (lu) begin
            pc_we      = 1'b0;
            ifid_we    = 1'b0;
            idex_flush = 1'b1;
          end
        end
        MD_WAIT: begin
          pc_we       = 1'b0;
          ifid_we     = 1'b0;
          idex_we     = 1'b0;
          exmem_flush = 1'b1;
          md_busy     = 1'b1;
          md_cnt_d    = md_cnt_q - 4'd1;
          if (md_cnt_q == 4'd1) begin
            state_d = RUN;
          end
        end
        default: begin
          state_d  = RUN;
          md_cnt_d = 4'd0;
        end
      endcase
    end
  end

  always_comb begin
    stall_d = stall_q;
    if (perf_clr) begin
      stall_d = '0;
    end else if (!pc_we && (stall_q != {CNT_W{1'b1}})) begin
      stall_d = stall_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= RUN;
      md_cnt_q <= 4'd0;
      stall_q  <= '0;
    end else begin
      state_q  <= state_d;
      md_cnt_q <= md_cnt_d;
      stall_q  <= stall_d;
    end
  end

  assign stall_cycles = stall_q;

  fwd_unit u_fwd (
    .ex_rs        (ex_rs),
    .ex_rt        (ex_rt),
    .mem_rd       (mem_rd),
    .mem_regwrite (mem_regwrite),
    .wb_rd        (wb_rd),
    .wb_regwrite  (wb_regwrite),
    .fwd_a        (fwd_a),
    .fwd_b        (fwd_b)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl; a second instance with a 4-bit counter covers saturation.
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] id_rs, id_rt, ex_rs, ex_rt, ex_rd, mem_rd, wb_rd;
  logic       id_uses_rt, ex_memread, mem_regwrite, wb_regwrite;
  logic       branch_taken, md_start, perf_clr;

  logic        pc_we, ifid_we, ifid_flush, idex_we, idex_flush, exmem_flush, md_busy;
  logic [1:0]  fwd_a, fwd_b;
  logic [31:0] stall_cycles;

  logic        s_pc_we, s_ifid_we, s_ifid_flush, s_idex_we, s_idex_flush, s_exmem_flush;
  logic        s_md_busy;
  logic [1:0]  s_fwd_a, s_fwd_b;
  logic [3:0]  s_stall_cycles;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.MD_LAT(4), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd), .ex_memread(ex_memread),
    .mem_rd(mem_rd), .mem_regwrite(mem_regwrite), .wb_rd(wb_rd), .wb_regwrite(wb_regwrite),
    .branch_taken(branch_taken), .md_start(md_start), .perf_clr(perf_clr),
    .pc_we(pc_we), .ifid_we(ifid_we), .ifid_flush(ifid_flush), .idex_we(idex_we),
    .idex_flush(idex_flush), .exmem_flush(exmem_flush), .fwd_a(fwd_a), .fwd_b(fwd_b),
    .md_busy(md_busy), .stall_cycles(stall_cycles)
  );

  hazard_ctrl #(.MD_LAT(4), .CNT_W(4)) dut_sat (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd), .ex_memread(ex_memread),
    .mem_rd(mem_rd), .mem_regwrite(mem_regwrite), .wb_rd(wb_rd), .wb_regwrite(wb_regwrite),
    .branch_taken(branch_taken), .md_start(md_start), .perf_clr(perf_clr),
    .pc_we(s_pc_we), .ifid_we(s_ifid_we), .ifid_flush(s_ifid_flush), .idex_we(s_idex_we),
    .idex_flush(s_idex_flush), .exmem_flush(s_exmem_flush), .fwd_a(s_fwd_a), .fwd_b(s_fwd_b),
    .md_busy(s_md_busy), .stall_cycles(s_stall_cycles)
  );

  task automatic idle_inputs();
    id_rs = 5'd0; id_rt = 5'd0; id_uses_rt = 1'b0;
    ex_rs = 5'd0; ex_rt = 5'd0; ex_rd = 5'd0; ex_memread = 1'b0;
    mem_rd = 5'd0; mem_regwrite = 1'b0; wb_rd = 5'd0; wb_regwrite = 1'b0;
    branch_taken = 1'b0; md_start = 1'b0; perf_clr = 1'b0;
  endtask

  // Clears both counters over one edge; pc_we stays high with idle inputs.
  task automatic clear_counters();
    @(negedge clk);
    idle_inputs();
    perf_clr = 1'b1;
    @(negedge clk);
    perf_clr = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (pc_we !== 1'b0 || ifid_we !== 1'b0 || idex_we !== 1'b0) begin
      errors++;
      $display("FAIL reset_we: pc/ifid/idex_we=%b%b%b required 000", pc_we, ifid_we, idex_we);
    end
    checks++;
    if ({ifid_flush, idex_flush, exmem_flush} !== 3'b111) begin
      errors++;
      $display("FAIL reset_flush: flushes=%b required 111", {ifid_flush, idex_flush, exmem_flush});
    end
    checks++;
    if (md_busy !== 1'b0 || fwd_a !== 2'b00 || fwd_b !== 2'b00 || stall_cycles !== 32'd0) begin
      errors++;
      $display("FAIL reset_misc: busy=%b fwd_a=%b fwd_b=%b stall=%0d required 0 00 00 0",
               md_busy, fwd_a, fwd_b, stall_cycles);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if ({pc_we, ifid_we, idex_we} !== 3'b111 ||
        {ifid_flush, idex_flush, exmem_flush} !== 3'b000) begin
      errors++;
      $display("FAIL reset_release: we=%b flush=%b required 111 000",
               {pc_we, ifid_we, idex_we}, {ifid_flush, idex_flush, exmem_flush});
    end
    @(negedge clk);
    checks++;
    if (stall_cycles !== 32'd0) begin
      errors++;
      $display("FAIL reset_count: stall=%0d required 0", stall_cycles);
    end
  endtask

  task automatic test_load_use();
    clear_counters();
    // rt match ignored when the ID instruction does not read rt.
    ex_memread = 1'b1; ex_rd = 5'd8; id_rt = 5'd8; id_rs = 5'd3; id_uses_rt = 1'b0;
    #1;
    checks++;
    if (pc_we !== 1'b1 || idex_flush !== 1'b0) begin
      errors++;
      $display("FAIL lu_rt_unused: pc_we=%b idex_flush=%b required 1 0", pc_we, idex_flush);
    end
    ex_rd = 5'd0; id_rs = 5'd0;
    #1;
    checks++;
    if (pc_we !== 1'b1) begin
      errors++;
      $display("FAIL lu_reg_zero: pc_we=%b required 1", pc_we);
    end
    ex_rd = 5'd8; id_rs = 5'd8; id_rt = 5'd0;
    #1;
    checks++;
    if ({pc_we, ifid_we, idex_we, idex_flush, ifid_flush} !== 5'b00110) begin
      errors++;
      $display("FAIL lu_stall: pc/ifid/idex_we,idex/ifid_flush=%b required 00110",
               {pc_we, ifid_we, idex_we, idex_flush, ifid_flush});
    end
    @(negedge clk);
    ex_memread = 1'b0; ex_rd = 5'd0; ex_rs = 5'd8; mem_rd = 5'd8; mem_regwrite = 1'b1;
    #1;
    checks++;
    if (fwd_a !== 2'b10 || pc_we !== 1'b1 || stall_cycles !== 32'd1) begin
      errors++;
      $display("FAIL lu_forward: fwd_a=%b pc_we=%b stall=%0d required 10 1 1",
               fwd_a, pc_we, stall_cycles);
    end
    @(negedge clk);
    idle_inputs();
    id_rt = 5'd9; id_uses_rt = 1'b1; ex_memread = 1'b1; ex_rd = 5'd9;
    #1;
    checks++;
    if (pc_we !== 1'b0 || idex_flush !== 1'b1) begin
      errors++;
      $display("FAIL lu_rt: pc_we=%b idex_flush=%b required 0 1", pc_we, idex_flush);
    end
    @(negedge clk);
    idle_inputs();
    #1;
    checks++;
    if (stall_cycles !== 32'd2) begin
      errors++;
      $display("FAIL lu_count: stall=%0d required 2", stall_cycles);
    end
  endtask

  task automatic test_forward_priority();
    @(negedge clk);
    idle_inputs();
    mem_rd = 5'd5; wb_rd = 5'd5; mem_regwrite = 1'b1; wb_regwrite = 1'b1; ex_rt = 5'd5;
    #1;
    checks++;
    if (fwd_b !== 2'b10 || fwd_a !== 2'b00) begin
      errors++;
      $display("FAIL fwd_mem_prio: fwd_b=%b fwd_a=%b required 10 00", fwd_b, fwd_a);
    end
    mem_regwrite = 1'b0;
    #1;
    checks++;
    if (fwd_b !== 2'b01) begin
      errors++;
      $display("FAIL fwd_wb: fwd_b=%b required 01", fwd_b);
    end
    mem_regwrite = 1'b1; mem_rd = 5'd6; ex_rs = 5'd5;
    #1;
    checks++;
    if (fwd_a !== 2'b01 || fwd_b !== 2'b01) begin
      errors++;
      $display("FAIL fwd_a_wb: fwd_a=%b fwd_b=%b required 01 01", fwd_a, fwd_b);
    end
    ex_rs = 5'd0; ex_rt = 5'd0; mem_rd = 5'd0; wb_rd = 5'd0;
    #1;
    checks++;
    if (fwd_a !== 2'b00 || fwd_b !== 2'b00) begin
      errors++;
      $display("FAIL fwd_zero: fwd_a=%b fwd_b=%b required 00 00", fwd_a, fwd_b);
    end
  endtask

  task automatic test_branch();
    clear_counters();
    ex_memread = 1'b1; ex_rd = 5'd7; id_rs = 5'd7; branch_taken = 1'b1;
    #1;
    checks++;
    if ({pc_we, ifid_flush, idex_flush, exmem_flush} !== 4'b1110) begin
      errors++;
      $display("FAIL branch_lu: pc_we,ifid/idex/exmem_flush=%b required 1110",
               {pc_we, ifid_flush, idex_flush, exmem_flush});
    end
    @(negedge clk);
    idle_inputs();
    branch_taken = 1'b1; md_start = 1'b1;
    #1;
    checks++;
    if (pc_we !== 1'b1 || exmem_flush !== 1'b0 || ifid_flush !== 1'b1) begin
      errors++;
      $display("FAIL branch_md: pc_we=%b exmem_flush=%b ifid_flush=%b required 1 0 1",
               pc_we, exmem_flush, ifid_flush);
    end
    @(negedge clk);
    idle_inputs();
    #1;
    checks++;
    if (md_busy !== 1'b0 || pc_we !== 1'b1 || stall_cycles !== 32'd0) begin
      errors++;
      $display("FAIL branch_after: busy=%b pc_we=%b stall=%0d required 0 1 0",
               md_busy, pc_we, stall_cycles);
    end
  endtask

  task automatic test_muldiv();
    clear_counters();
    for (int i = 0; i < 4; i++) begin
      md_start = (i == 0 || i == 2);
      #1;
      checks++;
      if (pc_we !== 1'b0 || exmem_flush !== 1'b1 || md_busy !== (i > 0)) begin
        errors++;
        $display("FAIL md_cycle%0d: pc_we=%b exmem_flush=%b busy=%b required 0 1 %0d",
                 i, pc_we, exmem_flush, md_busy, (i > 0));
      end
      @(negedge clk);
    end
    md_start = 1'b0;
    #1;
    checks++;
    if (pc_we !== 1'b1 || md_busy !== 1'b0 || exmem_flush !== 1'b0) begin
      errors++;
      $display("FAIL md_done: pc_we=%b busy=%b exmem_flush=%b required 1 0 0",
               pc_we, md_busy, exmem_flush);
    end
    checks++;
    if (stall_cycles !== 32'd4) begin
      errors++;
      $display("FAIL md_count: stall=%0d required 4", stall_cycles);
    end
  endtask

  task automatic test_reset_mid_md();
    @(negedge clk);
    idle_inputs();
    md_start = 1'b1;
    @(negedge clk);
    md_start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (pc_we !== 1'b0 || md_busy !== 1'b0 || exmem_flush !== 1'b1) begin
      errors++;
      $display("FAIL mid_rst: pc_we=%b busy=%b exmem_flush=%b required 0 0 1",
               pc_we, md_busy, exmem_flush);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (pc_we !== 1'b1 || md_busy !== 1'b0) begin
      errors++;
      $display("FAIL mid_release: pc_we=%b busy=%b required 1 0", pc_we, md_busy);
    end
    @(negedge clk);
    #1;
    checks++;
    if (pc_we !== 1'b1 || stall_cycles !== 32'd0) begin
      errors++;
      $display("FAIL mid_residual: pc_we=%b stall=%0d required 1 0", pc_we, stall_cycles);
    end
  endtask

  task automatic test_saturation();
    clear_counters();
    ex_memread = 1'b1; ex_rd = 5'd4; id_rs = 5'd4;
    repeat (20) @(negedge clk);
    #1;
    checks++;
    if (stall_cycles !== 32'd20 || s_stall_cycles !== 4'd15) begin
      errors++;
      $display("FAIL saturate: stall=%0d sat_stall=%0d required 20 15",
               stall_cycles, s_stall_cycles);
    end
    perf_clr = 1'b1;
    @(negedge clk);
    perf_clr = 1'b0;
    idle_inputs();
    #1;
    checks++;
    if (stall_cycles !== 32'd0 || s_stall_cycles !== 4'd0) begin
      errors++;
      $display("FAIL perf_clr: stall=%0d sat_stall=%0d required 0 0",
               stall_cycles, s_stall_cycles);
    end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_forward_priority();
    test_branch();
    test_muldiv();
    test_reset_mid_md();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline controller for the 5-stage MIPS core. It sequences the IF/ID, ID/EX, EX/MEM and MEM/WB buffers.
- Detects load-use hazards and inserts a one-cycle bubble.
- Flushes on taken branches and holds the pipeline during multi-cycle mul/div.
- Drives the EX-stage forwarding selects from the EX/MEM and MEM/WB destination fields.
- Keeps a saturating stall-cycle counter for performance measurement.

Parameters:
- MD_LAT, 4, mul/div latency in cycles including the issue cycle; legal range 2..16.
- CNT_W, 32, width of the stall-cycle counter.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- id_rs  in  5  rs field of the instruction in ID.
- id_rt  in  5  rt field of the instruction in ID.
- id_uses_rt  in  1  ID instruction reads rt.
- ex_rs  in  5  rs of the instruction in EX.
- ex_rt  in  5  rt of the instruction in EX.
- ex_rd  in  5  destination (mux output) of the instruction in EX.
- ex_memread  in  1  EX instruction is a load.
- mem_rd  in  5  EX/MEM destination register.
- mem_regwrite  in  1  EX/MEM WB write enable.
- wb_rd  in  5  MEM/WB destination register.
- wb_regwrite  in  1  MEM/WB WB write enable.
- branch_taken  in  1  EX resolved a taken branch or jump.
- md_start  in  1  EX holds a mul/div issuing this cycle.
- perf_clr  in  1  synchronous clear of stall_cycles.
- pc_we  out  1  PC write enable.
- ifid_we  out  1  IF/ID write enable.
- ifid_flush  out  1  IF/ID loads a NOP.
- idex_we  out  1  ID/EX write enable.
- idex_flush  out  1  ID/EX loads a bubble (control bits zero).
- exmem_flush  out  1  EX/MEM loads a bubble.
- fwd_a  out  2  ALU operand A select: 00 regfile, 10 EX/MEM, 01 MEM/WB.
- fwd_b  out  2  ALU operand B select, same encoding as fwd_a.
- md_busy  out  1  mul/div in progress.
- stall_cycles  out  CNT_W  count of cycles with pc_we=0.

Behaviour:
- Reset values while rst is high: state RUN, md_cnt 0, stall_cycles 0, pc_we=ifid_we=idex_we=0, ifid_flush=idex_flush=exmem_flush=1, fwd_a=fwd_b=00, md_busy=0.
- FSM states RUN and MD_WAIT.
- Registered state: state, 4-bit md_cnt, stall_cycles. All other outputs are combinational from state and inputs, with zero-cycle latency.
- RUN default outputs: pc_we=ifid_we=idex_we=1, all flushes 0.
- Load-use hazard in RUN:
  - Condition: lu = ex_memread & ex_rd!=0 & (ex_rd==id_rs | (id_uses_rt & ex_rd==id_rt)).
  - Response: pc_we=0, ifid_we=0, idex_flush=1 for exactly one cycle. The load then moves to MEM, lu drops, and the forward comes from EX/MEM.
- Branch in RUN:
  - branch_taken → ifid_flush=1, idex_flush=1, pc_we=1.
  - Branch has priority over lu, because the dependent ID instruction is squashed.
- Mul/div issue in RUN:
  - md_start & !branch_taken → next state MD_WAIT, md_cnt=MD_LAT-1.
  - The issue cycle itself stalls: pc_we=ifid_we=idex_we=0, exmem_flush=1.
- MD_WAIT:
  - Outputs: pc_we=ifid_we=idex_we=0, exmem_flush=1, md_busy=1.
  - md_cnt decrements each cycle. In the cycle with md_cnt==1, next state is RUN.
  - Total stall is MD_LAT cycles, including the issue cycle. The EX result is valid on the following RUN cycle, when EX/MEM captures it.
  - branch_taken, lu and md_start are ignored in MD_WAIT. Upstream never asserts branch_taken with md_start.
- md_start together with branch_taken: branch wins and md_start is dropped.
- Forwarding, evaluated in every state:
  - fwd_a=10 if mem_regwrite & mem_rd!=0 & mem_rd==ex_rs.
  - Else fwd_a=01 if wb_regwrite & wb_rd!=0 & wb_rd==ex_rs.
  - Else fwd_a=00.
  - fwd_b uses the same rules with ex_rt.
  - EX/MEM takes priority over MEM/WB. Register $0 is never forwarded.
- stall_cycles:
  - Increments on each clock edge where rst=0 and pc_we=0, saturating at all-ones.
  - perf_clr has priority over increment, so the counter reads 0 after the edge.
- rst asserted mid-MD_WAIT: immediately returns to RUN after deassert with md_cnt 0. No residual stall.

Decomposition:
- Shared package mips_pkg:
  - forwarding select constants FWD_RF=00, FWD_MEM=10, FWD_WB=01.
  - FSM state encoding RUN/MD_WAIT.
  - REG_ZERO=5'd0.
- One natural sub-module: fwd_unit, a combinational forwarding compare instanced once and producing both fwd_a and fwd_b. The FSM, hazard logic and counter stay in hazard_ctrl.

Test Plan:
- Reset: hold rst 3 cycles, release with no hazards → during rst pc_we=0 and all flushes=1; first cycle after release pc_we=1, flushes 0, stall_cycles=0.
- Load-use: ex_memread=1, ex_rd=8, id_rs=8 → one cycle of pc_we=0, ifid_we=0, idex_flush=1. Next cycle mem_rd=8, mem_regwrite=1, ex_rs=8 → fwd_a=10, stall_cycles=1.
- Forward priority: mem_rd=wb_rd=5, both regwrite=1, ex_rt=5 → fwd_b=10. Set mem_regwrite=0 → fwd_b=01. Set ex_rt=0 with all rd=0 → fwd_b=00.
- Branch vs load-use: branch_taken=1 with lu conditions true → pc_we=1, ifid_flush=1, idex_flush=1, stall_cycles unchanged.
- Mul/div, MD_LAT=4:
  - md_start pulse → pc_we=0 and exmem_flush=1 for 4 consecutive cycles, md_busy=1 for the last 3; stall_cycles=4.
  - md_start reasserted in MD_WAIT → no extension of the stall.
- Reset mid-operation / saturation:
  - rst pulsed on the 2nd MD_WAIT cycle → after release state RUN and pc_we=1.
  - With CNT_W=4, 20 stall cycles → stall_cycles=15.
  - perf_clr → 0.
